// File: rtl/snes_poll_master.sv
// snes_poll_master: SNES controller port bus master.
// Generates the latch pulse and 16 serial clocks, samples snes_data (active-low)
// and presents the decoded 16-bit button word (bit0 = B, 1 = pressed).
// Optional feature macro: SNES_POLL_AUTO_EN enables periodic auto-polling with
// a pending flag for triggers that arrive while a poll is running.
module snes_poll_master #(
    parameter int unsigned HALF_CYCLES   = 144,
    parameter int unsigned PERIOD_CYCLES = 400000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        poll_req,
    output logic        poll_ack,
    output logic        busy,
    output logic        snes_latch,
    output logic        snes_clk,
    input  logic        snes_data,
    output logic [15:0] state,
    output logic        valid
);

    localparam int HW = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_LOW,
        S_HIGH,
        S_DONE
    } fsm_t;

    fsm_t          r_fsm;
    fsm_t          w_fsm_nxt;
    logic [HW-1:0] r_half_cnt;
    logic          r_latch_half;
    logic [4:0]    r_bit_cnt;
    logic [15:0]   r_shift;
    logic [15:0]   r_state;
    logic          r_snes_latch;
    logic          r_snes_clk;

    logic          w_half_end;
    logic          w_can_accept;
    logic          w_start;
    logic          w_sample;
    logic          w_busy;

    assign w_half_end   = (r_half_cnt == HW'(HALF_CYCLES - 1));
    assign w_busy       = (r_fsm == S_LATCH) || (r_fsm == S_LOW) || (r_fsm == S_HIGH);
    // The DONE cycle behaves like IDLE for acceptance so polls can run back-to-back.
    assign w_can_accept = (r_fsm == S_IDLE) || (r_fsm == S_DONE);

`ifdef SNES_POLL_AUTO_EN
    localparam int PW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;

    logic [PW-1:0] r_period_cnt;
    logic          r_pending;
    logic          w_auto_trig;

    assign w_auto_trig = (r_period_cnt == PW'(PERIOD_CYCLES - 1));
    assign w_start     = w_can_accept && (poll_req || w_auto_trig || r_pending);

    // Free-running period counter; the trigger fires in the wrap cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period_cnt <= '0;
        end else if (w_auto_trig) begin
            r_period_cnt <= '0;
        end else begin
            r_period_cnt <= r_period_cnt + 1'b1;
        end
    end

    // A trigger that cannot start a poll immediately is remembered until IDLE/DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
        end else if (w_start) begin
            r_pending <= 1'b0;
        end else if (w_auto_trig) begin
            r_pending <= 1'b1;
        end
    end
`else
    assign w_start = w_can_accept && poll_req;
`endif

    // Sample on the last LATCH cycle (bit0) and the last HIGH cycle of pulses 1..15.
    assign w_sample = w_half_end && (r_bit_cnt < 5'd16) &&
                      (((r_fsm == S_LATCH) && r_latch_half) || (r_fsm == S_HIGH));

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // sees the pre-edge values of the others, exactly like the hardware.
            r_fsm <= w_fsm_nxt;
        end
    end

    // FSM next-state logic: LATCH spans two half-periods, then 16 LOW/HIGH pulses.
    always_comb begin
        // NOTE: default assignment first so no path leaves w_fsm_nxt unassigned,
        // which would otherwise infer a latch.
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            S_IDLE, S_DONE: w_fsm_nxt = w_start ? S_LATCH : S_IDLE;
            S_LATCH:        if (w_half_end && r_latch_half) w_fsm_nxt = S_LOW;
            S_LOW:          if (w_half_end) w_fsm_nxt = S_HIGH;
            S_HIGH:         if (w_half_end) w_fsm_nxt = (r_bit_cnt == 5'd16) ? S_DONE : S_LOW;
            default:        w_fsm_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: acceptance pulse, busy level and the result strobe.
    always_comb begin
        poll_ack = w_start;
        busy     = w_busy;
        valid    = (r_fsm == S_DONE);
    end

    // Half-period timer and LATCH half tracker; the timer reloads at each phase edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_half_cnt   <= '0;
            r_latch_half <= 1'b0;
        end else begin
            if (w_busy && !w_half_end) begin
                r_half_cnt <= r_half_cnt + 1'b1;
            end else begin
                r_half_cnt <= '0;
            end
            if ((r_fsm == S_LATCH) && w_half_end) begin
                r_latch_half <= ~r_latch_half;
            end
        end
    end

    // Pulse index: 0 during LATCH, k during pulse k, holds at 16 until the next poll.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= '0;
        end else if (w_start) begin
            r_bit_cnt <= '0;
        end else if ((r_fsm == S_LATCH) && w_half_end && r_latch_half) begin
            r_bit_cnt <= 5'd1;
        end else if ((r_fsm == S_HIGH) && w_half_end && (r_bit_cnt != 5'd16)) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

    // Shift register capture and whole-word commit of the inverted (active-high) result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_state <= '0;
        end else begin
            if (w_sample) begin
                r_shift[r_bit_cnt[3:0]] <= snes_data;
            end
            if ((r_fsm == S_HIGH) && (w_fsm_nxt == S_DONE)) begin
                r_state <= ~r_shift;
            end
        end
    end

    // Registered pad drivers, derived from the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snes_latch <= 1'b0;
            r_snes_clk   <= 1'b1;
        end else begin
            r_snes_latch <= (w_fsm_nxt == S_LATCH);
            r_snes_clk   <= (w_fsm_nxt != S_LOW);
        end
    end

    assign snes_latch = r_snes_latch;
    assign snes_clk   = r_snes_clk;
    assign state      = r_state;

endmodule

// File: tb/tb_snes_poll_master.sv
// Testbench for snes_poll_master. A timing model derived from the poll-cycle
// offsets (cycle n after acceptance) predicts every output on every cycle.
module tb_snes_poll_master;

    localparam int H = 4;
    localparam int P = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        poll_req = 1'b0;
    logic        poll_ack;
    logic        busy;
    logic        snes_latch;
    logic        snes_clk;
    logic        snes_data = 1'b1;
    logic [15:0] state;
    logic        valid;

    snes_poll_master #(.HALF_CYCLES(H), .PERIOD_CYCLES(P)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .poll_req   (poll_req),
        .poll_ack   (poll_ack),
        .busy       (busy),
        .snes_latch (snes_latch),
        .snes_clk   (snes_clk),
        .snes_data  (snes_data),
        .state      (state),
        .valid      (valid)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 20)
                $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycle bookkeeping
    int cyc = 0;
    int rc  = 0;   // posedges since reset release (auto-poll period phase)
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) rc = 0;
        else        rc++;
    end

    // Model state
    int          t0 = -1;
    logic [15:0] m_shift = '0;
    logic [15:0] m_state = '0;
    bit          m_pend = 0;
    bit          auto_en;
    int          n_ack = 0, n_valid = 0;
    int          last_ack = -1, last_valid = -1, prev_valid = -1;

    initial begin
`ifdef SNES_POLL_AUTO_EN
        auto_en = 1;
`else
        auto_en = 0;
`endif
    end

    task automatic model_reset();
        t0 = -1; m_shift = '0; m_state = '0; m_pend = 0;
    endtask

    // Reference model + compare, evaluated mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            int  n;
            bit  e_latch, e_busy, e_low, e_valid, e_ack, can, trig;
            n       = (t0 >= 0) ? cyc - t0 : -1;
            e_latch = (n >= 1) && (n <= 2*H);
            e_busy  = (n >= 1) && (n <= 34*H);
            e_low   = (n >= 2*H+1) && (n <= 34*H) && (((n-1) % (2*H)) < H);
            e_valid = (n == 34*H+1);
            if (n == 2*H) m_shift[0] = snes_data;
            else if (n >= 4*H && n <= 32*H && (n % (2*H)) == 0) m_shift[n/(2*H)-1] = snes_data;
            if (e_valid) m_state = ~m_shift;
            can   = (t0 < 0) || (n >= 34*H+1);
            trig  = auto_en && ((rc % P) == P-1);
            e_ack = can && (poll_req || trig || m_pend);

            check("poll_ack",   poll_ack,   e_ack);
            check("busy",       busy,       e_busy);
            check("snes_latch", snes_latch, e_latch);
            check("snes_clk",   snes_clk,   !e_low);
            check("valid",      valid,      e_valid);
            check("state",      state,      m_state);

            if (poll_ack) begin n_ack++; last_ack = cyc; end
            if (valid) begin n_valid++; prev_valid = last_valid; last_valid = cyc; end

            if (e_ack) begin t0 = cyc; m_pend = 0; end
            else if (trig) m_pend = 1;
        end
    end

    // Stimulus: controller model or random data
    bit          ctrl_mode = 0;
    logic [15:0] raw = 16'hFFFF;
    int          idx = 16;
    logic        prev_clk = 1'b1;
    int          falls = 0;

    task automatic step();
        @(posedge clk);
        #1;
        if (ctrl_mode) begin
            if (snes_latch) idx = 0;
            else if (snes_clk && !prev_clk && idx < 16) idx++;
            snes_data = (idx < 16) ? raw[idx[3:0]] : 1'b1;
        end else begin
            snes_data = 1'($urandom_range(0, 1));
        end
        if (prev_clk && !snes_clk) falls++;
        prev_clk = snes_clk;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        model_reset();
        step(); step();
        rst_n = 1'b1;
        prev_clk = 1'b1;
    endtask

    task automatic wait_valid(input int budget);
        int start_v;
        int k;
        start_v = n_valid;
        k = 0;
        while (n_valid == start_v && k < budget) begin step(); k++; end
        if (n_valid == start_v) check("valid_timeout", 0, 1);
    endtask

    task automatic directed_poll(input logic [15:0] pattern, input logic [15:0] exp_state, input string tag);
        ctrl_mode = 1; raw = pattern; falls = 0;
        poll_req = 1'b1;
        step();
        poll_req = 1'b0;
        wait_valid(400);
        check({tag, "_latency"}, last_valid - last_ack, 34*H+1);
        check({tag, "_state"},   state, exp_state);
        check({tag, "_pulses"},  falls, 16);
    endtask

    initial begin
        int v0, a0, k, rel;
        do_reset();
        repeat (3) step();

        // Directed polls through a real controller model
        directed_poll(16'hFFFE, 16'h0001, "b_only");
        step();
        directed_poll(16'h5A3C, 16'hA5C3, "pat5a3c");
        step();

        // Reset in the middle of LATCH: outputs fall back immediately
        poll_req = 1'b1; step(); poll_req = 1'b0;
        step(); step();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_latch", snes_latch, 1'b0);
        check("rst_clk",   snes_clk,   1'b1);
        check("rst_busy",  busy,       1'b0);
        check("rst_state", state,      16'h0000);
        check("rst_valid", valid,      1'b0);
        step(); step();
        rst_n = 1'b1;
        v0 = n_valid;
        repeat (200) step();
        check("rst_no_valid", n_valid - v0, 0);

        // Held request: back-to-back polls with the ack in each DONE cycle
        ctrl_mode = 0;
        poll_req = 1'b1;
        v0 = n_valid;
        k = 0;
        while (n_valid < v0 + 4 && k < 1000) begin step(); k++; end
        check("b2b_count",    n_valid - v0 >= 4, 1);
        check("b2b_interval", last_valid - prev_valid, 34*H+1);
        check("b2b_ack_done", last_ack, last_valid);

        // Random requests and random data on every cycle
        for (int i = 0; i < 3000; i++) begin
            poll_req = ($urandom_range(0, 39) == 0);
            step();
        end
        poll_req = 1'b0;

`ifdef SNES_POLL_AUTO_EN
        // Auto-poll: first trigger at period phase P-1, next one pends into DONE
        do_reset();
        rel = cyc;
        a0 = n_ack;
        k = 0;
        while (n_ack == a0 && k < 300) begin step(); k++; end
        check("auto_first_ack", last_ack - rel, P-1);
        a0 = last_ack;
        k = 0;
        while (last_ack == a0 && k < 300) begin step(); k++; end
        check("auto_pend_ack", last_ack - a0, 34*H+1);

        // poll_req coincident with the auto trigger: a single acceptance
        do_reset();
        k = 0;
        while (rc != P-1 && k < 300) begin step(); k++; end
        a0 = n_ack;
        poll_req = 1'b1;
        step();
        poll_req = 1'b0;
        check("coinc_one_ack", n_ack - a0, 1);
        wait_valid(400);
`endif

        repeat (5) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
